// File: rtl/instr_encoder.sv
// instr_encoder: packs register/immediate request fields into 16-bit instruction words.
// Build option INSTR_ENCODER_LI_EN enables the two-word load-immediate expansion.
`default_nettype none

module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_li,
  input  logic [3:0]  req_rd,
  input  logic [3:0]  req_rs1,
  input  logic [3:0]  req_rs2,
  input  logic [15:0] req_imm,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [15:0] ins_data,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EMIT1 = 2'd1;
`ifdef INSTR_ENCODER_LI_EN
  localparam logic [1:0] EMIT2 = 2'd2;
`endif

  logic [1:0]  state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;

  logic signed [15:0] simm;
  logic        fit_j, fit_b, fit_i;
  logic [15:0] enc_word;
  logic        enc_bad;

  assign simm  = req_imm;
  assign fit_j = (simm >= -16'sd256) && (simm <= 16'sd254) && !req_imm[0];
  assign fit_b = (simm >= -16'sd16)  && (simm <= 16'sd14)  && !req_imm[0];
  assign fit_i = (simm >= -16'sd8)   && (simm <= 16'sd7);

`ifdef INSTR_ENCODER_LI_EN
  logic [15:0] li_lo, li_rem, li_word1, li_word2;
  logic        li_bad, li_second;
  logic        pend_q, pend_d;
  logic [15:0] word2_q, word2_d;

  // lo is the sign-extended low nibble; the remainder must be a whole lui page.
  assign li_lo     = {{12{req_imm[3]}}, req_imm[3:0]};
  assign li_rem    = req_imm - li_lo;
  assign li_word1  = fit_i ? {req_imm[3:0], 4'h0, req_rd, 4'hC}
                           : {li_rem[15:8], req_rd, 4'hE};
  assign li_word2  = {req_imm[3:0], req_rd, req_rd, 4'hC};
  assign li_bad    = !fit_i && (li_rem[7:0] != 8'h00);
  assign li_second = !fit_i && (req_imm[3:0] != 4'h0);
`endif

  always_comb begin
    enc_word = 16'h0000;
    enc_bad  = 1'b0;
    case (req_op)
      4'b0000: begin
        enc_word = {req_imm[8:1], req_rd, req_op};
        enc_bad  = !fit_j;
      end
      4'b0001: begin
        enc_word = {req_imm[4:1], req_rs1, req_rd, req_op};
        enc_bad  = !fit_b;
      end
      4'b0010, 4'b0011: begin
        enc_word = {req_rs2, req_rs1, req_imm[4:1], req_op};
        enc_bad  = !fit_b;
      end
      4'b0100, 4'b0101, 4'b1100, 4'b1101: begin
        enc_word = {req_imm[3:0], req_rs1, req_rd, req_op};
        enc_bad  = !fit_i;
      end
      4'b0110, 4'b0111: begin
        enc_word = {req_rs2, req_rs1, req_imm[3:0], req_op};
        enc_bad  = !fit_i;
      end
      4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
        enc_word = {req_rs2, req_rs1, req_rd, req_op};
      end
      4'b1110: begin
        enc_word = {req_imm[15:8], req_rd, req_op};
        enc_bad  = (req_imm[7:0] != 8'h00);
      end
      default: enc_bad = 1'b1;
    endcase
`ifdef INSTR_ENCODER_LI_EN
    if (req_li) begin
      enc_word = li_word1;
      enc_bad  = li_bad;
    end
`else
    if (req_li) begin
      enc_bad = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = (state_q == IDLE) && req_valid && enc_bad;
`ifdef INSTR_ENCODER_LI_EN
    pend_d  = pend_q;
    word2_d = word2_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && !enc_bad) begin
          state_d = EMIT1;
          data_d  = enc_word;
`ifdef INSTR_ENCODER_LI_EN
          pend_d  = req_li && li_second;
          word2_d = li_word2;
`endif
        end
      end
      EMIT1: begin
        if (ins_ready) begin
`ifdef INSTR_ENCODER_LI_EN
          if (pend_q) begin
            state_d = EMIT2;
            data_d  = word2_q;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef INSTR_ENCODER_LI_EN
      EMIT2: begin
        if (ins_ready) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
`ifdef INSTR_ENCODER_LI_EN
      pend_q  <= 1'b0;
      word2_q <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef INSTR_ENCODER_LI_EN
      pend_q  <= pend_d;
      word2_q <= word2_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign ins_valid = (state_q != IDLE);
  assign ins_data  = data_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  encode request present.
REQ-004 req_ready  output  1  encoder accepts request this cycle (high only in IDLE).
REQ-005 req_op  input  4  opcode: 0000 jal, 0001 jalr, 0010 beq, 0011 ble, 0100 lb, 0101 lw, 0110 sb, 0111 sw, 1000-1011 R-type, 1100 addi, 1101 subi, 1110 lui, 1111 reserved.
REQ-006 req_li  input  1  pseudo-op "load immediate" (req_op ignored).
REQ-007 req_rd / req_rs1 / req_rs2  input  4 each  register fields.
REQ-008 req_imm  input  16  signed byte offset / immediate (lui: full 16-bit value).
REQ-009 ins_valid  output  1  ins_data holds an encoded instruction.
REQ-010 ins_ready  input  1  downstream consumes ins_data when ins_valid && ins_ready.
REQ-011 ins_data  output  16  encoded instruction.
REQ-012 err  output  1  one-cycle pulse: request rejected, nothing emitted.

Function
REQ-013 Layouts SHALL be: I-type (jalr, lb, lw, addi, subi) {imm4[15:12], rs1[11:8], rd[7:4], op}; S/B-type (sb, sw, beq, ble) {rs2[15:12], rs1[11:8], imm4[7:4], op}; R-type {rs2, rs1, rd, op}; jal/lui {imm8[15:8], rd[7:4], op}.
REQ-014 Field values SHALL be: jal imm8=req_imm[8:1]; jalr/beq/ble imm4=req_imm[4:1]; lb/lw/sb/sw/addi/subi imm4=req_imm[3:0]; lui imm8=req_imm[15:8].
REQ-015 Range checks, failing any SHALL give err: jal -256..254 even; jalr/beq/ble -16..14 even; lb/lw/sb/sw/addi/subi -8..7; lui req_imm[7:0]==0; op 1111 always fails; R-type never fails.
REQ-016 FSM states IDLE, EMIT1, EMIT2; IDLE->EMIT1 on accepted valid request; EMIT1->IDLE on handshake for single-word results; EMIT1->EMIT2 on handshake when a second word is pending; EMIT2->IDLE on handshake.
REQ-017 Rejected request SHALL pulse err the cycle after acceptance and remain in IDLE; ins_valid stays low.
REQ-018 Accept-to-ins_valid latency SHALL be exactly 1 cycle; ins_data SHALL be registered and stable while ins_valid && !ins_ready.
REQ-019 ins_valid SHALL be high in EMIT1/EMIT2 only; back-to-back words SHALL emit with no bubble when ins_ready is held high.
REQ-020 req_ready SHALL be low in EMIT1/EMIT2; a request asserted then is held off, never dropped or merged.
REQ-021 LI rule: lo=sext(req_imm[3:0]); if req_imm fits -8..7 emit single "addi rd, r0, lo"; else rem=req_imm-lo; if rem[7:0]!=0 reject; else emit "lui rd, rem[15:8]", then "addi rd, rd, lo" only if lo!=0.

Reset
REQ-022 On rst: state IDLE, ins_valid=0, ins_data=16'h0000, err=0, req_ready=1 the cycle after rst falls; pending second word discarded.
REQ-023 rst mid-sequence (EMIT1/EMIT2) SHALL abort with no further ins_valid.

Configuration
REQ-024 Macro INSTR_ENCODER_LI_EN: defined -> REQ-021 expansion and EMIT2 present; undefined -> req_li=1 SHALL be rejected with err, EMIT2 absent, all other behaviour identical.

Verification
REQ-025 addi rd=3 rs1=2 imm=-3 -> one word 16'hD23C, err=0.
REQ-026 jal rd=1 imm=+0x20 -> 16'h1010; jal imm=0x0003 (odd) -> err pulse, no ins_valid.
REQ-027 beq rs1=4 rs2=5 imm=-4 -> 16'h54E2; ins_ready held low 5 cycles -> ins_data unchanged, req_ready low throughout.
REQ-028 LI rd=6 imm=16'h12FF -> 16'h136E then 16'hF66C; imm=5 -> 16'h506C only; imm=16'h1200 -> 16'h126E only; imm=16'h012F -> err.
REQ-029 rst asserted during EMIT2 of LI 16'h12FF -> second word never emitted, ins_valid=0, ins_data=16'h0000.
REQ-030 op=1111 -> err; lui imm=16'h1234 -> err; LI with INSTR_ENCODER_LI_EN undefined -> err.
